// File: rtl/qpu_sched_pkg.sv
// Shared types for the QPU timed-event scheduler: condition codes, FSM states
// and the queue entry layout {time, mask, cond, data}.
package qpu_sched_pkg;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_ZERO   = 2'b01;
    localparam logic [1:0] COND_ONE    = 2'b10;
    localparam logic [1:0] COND_EQU    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Packed entry width: time + mask + 2-bit cond per channel + payload.
    function automatic int entry_w(input int time_w, input int ev_ch, input int ev_w);
        return time_w + 3 * ev_ch + ev_ch * ev_w;
    endfunction

endpackage

// File: rtl/qpu_sync_fifo.sv
// Synchronous FIFO with one-hot read/write pointers, occupancy count,
// simultaneous push/pop and a synchronous clear.
module qpu_sync_fifo #(
    parameter int DP = 8,
    parameter int DW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DP+1)-1:0]  count
);

    localparam int CW = $clog2(DP + 1);
    localparam logic [DP-1:0] PTR_INIT = {{(DP-1){1'b0}}, 1'b1};

    logic [DP-1:0] wr_ptr;
    logic [DP-1:0] rd_ptr;
    logic [DW-1:0] mem [DP];
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CW'(DP));
    assign empty   = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= PTR_INIT;
            rd_ptr <= PTR_INIT;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= PTR_INIT;
            rd_ptr <= PTR_INIT;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= {wr_ptr[DP-2:0], wr_ptr[DP-1]};
            if (do_pop)  rd_ptr <= {rd_ptr[DP-2:0], rd_ptr[DP-1]};
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only slots behind valid pointers are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DP; i++) begin
            if (do_push && wr_ptr[i]) mem[i] <= din;
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < DP; i++) begin
            if (rd_ptr[i]) dout = dout | mem[i];
        end
    end

endmodule

// File: rtl/qpu_timed_event_scheduler.sv
// Timed-event scheduler: queues time-stamped multi-channel events and releases
// each one when the local timer reaches its time, gated by measurement results.
module qpu_timed_event_scheduler
    import qpu_sched_pkg::*;
#(
    parameter int TIME_W   = 16,
    parameter int TQ_DEPTH = 8,
    parameter int EV_CH    = 4,
    parameter int EV_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            halt,
    input  logic                            flush,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [TIME_W-1:0]               wr_time,
    input  logic [EV_CH-1:0]                wr_mask,
    input  logic [2*EV_CH-1:0]              wr_cond,
    input  logic [EV_CH*EV_W-1:0]           wr_data,
    input  logic [EV_CH-1:0]                meas_zero,
    input  logic [EV_CH-1:0]                meas_one,
    input  logic [EV_CH-1:0]                meas_equ,
    output logic [EV_CH-1:0]                ev_o_valid,
    output logic [EV_CH-1:0]                ev_o_squash,
    output logic [EV_CH*EV_W-1:0]           ev_o_data,
    output logic [TIME_W-1:0]               timer_o,
    output logic                            run_o,
    output logic [$clog2(TQ_DEPTH+1)-1:0]   q_count,
    output logic                            err_late
);

    localparam int ENT_W = entry_w(TIME_W, EV_CH, EV_W);
    localparam int CNT_W = $clog2(TQ_DEPTH + 1);
    localparam int DAT_W = EV_CH * EV_W;

    function automatic logic cond_ok(input logic [1:0] code, input logic m_zero,
                                     input logic m_one, input logic m_equ);
        case (code)
            COND_ALWAYS: cond_ok = 1'b1;
            COND_ZERO:   cond_ok = m_zero;
            COND_ONE:    cond_ok = m_one;
            COND_EQU:    cond_ok = m_equ;
            default:     cond_ok = 1'b1;
        endcase
    endfunction

    state_t              state, state_nxt;
    logic [TIME_W-1:0]   timer_r;
    logic [TIME_W-1:0]   last_time;
    logic [TIME_W-1:0]   ref_time;
    logic [TIME_W-1:0]   delta;
    logic [TIME_W-1:0]   head_time;
    logic [ENT_W-1:0]    wr_ent, head_ent, sel_ent;
    logic                q_full, q_empty;
    logic [CNT_W-1:0]    cnt;
    logic                running, accept, in_order, bypass, late;
    logic                push, match, issue, last_pop, tick;
    logic [EV_CH-1:0]    sel_mask;
    logic [2*EV_CH-1:0]  sel_cond;
    logic [DAT_W-1:0]    sel_data;
    logic [EV_CH-1:0]    valid_p0, squash_p0;
    logic [DAT_W-1:0]    data_p0;
    logic [EV_CH-1:0]    valid_p1, squash_p1;
    logic [DAT_W-1:0]    data_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else if (halt) begin
            if (state == ST_RUN) state_nxt = ST_HALT;
        end else if (start && state != ST_RUN) begin
            state_nxt = ST_RUN;
        end
    end

    assign running = (state == ST_RUN);
    assign wr_ready = ~q_full & ~flush;
    assign accept   = wr_valid & wr_ready;

    // Wrap-safe ordering: new time must lie strictly ahead, within half the timer range.
    assign ref_time = q_empty ? timer_r : last_time;
    assign delta    = wr_time - ref_time;
    assign in_order = (delta != '0) & ~delta[TIME_W-1];
    assign bypass   = accept & q_empty & running & (delta == '0);
    assign push     = accept & in_order;
    assign late     = accept & ~in_order & ~bypass;

    assign wr_ent    = {wr_time, wr_mask, wr_cond, wr_data};
    assign head_time = head_ent[ENT_W-1 -: TIME_W];
    assign match     = running & ~q_empty & (head_time == timer_r) & ~flush;
    assign issue     = match | bypass;

    // Clock stops once the last queued entry issues, so the timer rests on its time.
    assign last_pop = match & ~push & (cnt == CNT_W'(1));
    assign tick     = running & ((~q_empty & ~last_pop) | bypass);

    qpu_sync_fifo #(
        .DP (TQ_DEPTH),
        .DW (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .pop   (match),
        .din   (wr_ent),
        .dout  (head_ent),
        .full  (q_full),
        .empty (q_empty),
        .count (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        timer_r <= '0;
        else if (flush) timer_r <= '0;
        else if (tick)  timer_r <= timer_r + TIME_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) last_time <= wr_time;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        err_late <= 1'b0;
        else if (flush) err_late <= 1'b0;
        else if (late)  err_late <= 1'b1;
    end

    // p0: condition evaluation on the issuing entry
    assign sel_ent  = match ? head_ent : wr_ent;
    assign sel_mask = sel_ent[DAT_W + 2*EV_CH +: EV_CH];
    assign sel_cond = sel_ent[DAT_W +: 2*EV_CH];
    assign sel_data = sel_ent[DAT_W-1:0];

    always_comb begin
        valid_p0  = '0;
        squash_p0 = '0;
        data_p0   = '0;
        for (int c = 0; c < EV_CH; c++) begin
            if (issue && sel_mask[c]) begin
                if (cond_ok(sel_cond[2*c +: 2], meas_zero[c], meas_one[c], meas_equ[c])) begin
                    valid_p0[c]             = 1'b1;
                    data_p0[c*EV_W +: EV_W] = sel_data[c*EV_W +: EV_W];
                end else begin
                    squash_p0[c] = 1'b1;
                end
            end
        end
    end

    // p1: registered event outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_p1  <= '0;
            squash_p1 <= '0;
            data_p1   <= '0;
        end else if (flush) begin
            valid_p1  <= '0;
            squash_p1 <= '0;
            data_p1   <= '0;
        end else begin
            valid_p1  <= valid_p0;
            squash_p1 <= squash_p0;
            data_p1   <= data_p0;
        end
    end

    assign ev_o_valid  = valid_p1;
    assign ev_o_squash = squash_p1;
    assign ev_o_data   = data_p1;
    assign timer_o     = timer_r;
    assign run_o       = running;
    assign q_count     = cnt;

endmodule
